// File: rtl/pa_fmau_align_sched_if.sv
// Bus bundle for the FMAU EX2 alignment-shifter scheduler.
// Carries:
//   - the two requester channels: vld/frac/diff in, rdy out;
//   - the shared shifter hookup: shf_data/shf_index out, shf_result in;
//   - the result channel: res_vld/res_id/res_data/res_sat out, res_rdy in;
//   - the pipeline kill: flush.
//
// Handshake rules:
//   - A request transfers on a clock edge where reqN_vld & reqN_rdy.
//   - A result transfers on a clock edge where res_vld & res_rdy.
//   - rdy is a combinational function of vld, so producers must not make
//     vld depend on rdy.
//   - res_* stays stable while res_vld & ~res_rdy.
//
// Modports:
//   - slave: the scheduler side.
//   - master: the requesters, shifter and consumer that surround it.
interface pa_fmau_align_sched_if #(
  parameter int DIFF_WIDTH = 10,
  parameter int DATA_WIDTH = 53
);
  logic                  req0_vld;
  logic [23:0]           req0_frac;
  logic [DIFF_WIDTH-1:0] req0_diff;
  logic                  req0_rdy;
  logic                  req1_vld;
  logic [23:0]           req1_frac;
  logic [DIFF_WIDTH-1:0] req1_diff;
  logic                  req1_rdy;
  logic [23:0]           shf_data;
  logic [5:0]            shf_index;
  logic [DATA_WIDTH-1:0] shf_result;
  logic                  res_vld;
  logic                  res_id;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_sat;
  logic                  res_rdy;
  logic                  flush;

  modport slave (
    input  req0_vld, req0_frac, req0_diff,
    output req0_rdy,
    input  req1_vld, req1_frac, req1_diff,
    output req1_rdy,
    output shf_data, shf_index,
    input  shf_result,
    output res_vld, res_id, res_data, res_sat,
    input  res_rdy, flush
  );

  modport master (
    output req0_vld, req0_frac, req0_diff,
    input  req0_rdy,
    output req1_vld, req1_frac, req1_diff,
    input  req1_rdy,
    input  shf_data, shf_index,
    output shf_result,
    input  res_vld, res_id, res_data, res_sat,
    output res_rdy, flush
  );
endinterface

// File: rtl/pa_fmau_align_sched.sv
// Scheduler for the shared src2 alignment right-shifter in FMAU EX2.
//
// Requesters:
//   - req0: FMA addend alignment.
//   - req1: FADD/FSUB small-operand alignment.
//
// Operation:
//   - Round-robin arbitration picks one requester per cycle.
//   - The winner's signed exponent difference is saturated into a 6-bit
//     shifter index.
//   - The external combinational shifter's output is captured into a
//     one-entry result register tagged with the winner's id.
//
// Ports:
//   forever_cpuclk  clock
//   cpurst          synchronous active-high reset
//   bus             pa_fmau_align_sched_if.slave (requests, shifter, result, flush)
module pa_fmau_align_sched #(
  parameter int DIFF_WIDTH = 10,
  parameter int DATA_WIDTH = 53,
  parameter int MAX_SHIFT  = 51
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  pa_fmau_align_sched_if.slave   bus
);

  localparam logic signed [DIFF_WIDTH-1:0] SAT_DIFF = DIFF_WIDTH'(MAX_SHIFT);
  localparam logic [5:0]                   SAT_IDX  = 6'(MAX_SHIFT);

  logic                         rr_ptr;
  logic                         grant;
  logic                         any_vld;
  logic                         can_acc;
  logic                         accept;
  logic                         win_sat;
  logic [23:0]                  win_frac;
  logic signed [DIFF_WIDTH-1:0] win_diff;
  logic [5:0]                   win_idx;

  // Arbitration and operand mux.
  // With no request pending, req0 is selected, so the shifter inputs are
  // don't-care but stay deterministic.
  always_comb begin
    any_vld  = bus.req0_vld | bus.req1_vld;
    grant    = (bus.req0_vld & bus.req1_vld) ? rr_ptr : bus.req1_vld;
    win_frac = grant ? bus.req1_frac : bus.req0_frac;
    win_diff = $signed(grant ? bus.req1_diff : bus.req0_diff);
  end

  // Index saturation.
  // Negative differences need no shift. Differences of MAX_SHIFT or more
  // push the whole operand into the sticky bit, so they clamp to MAX_SHIFT
  // and set res_sat. The index therefore always stays inside the shifter's
  // legal range.
  always_comb begin
    win_sat = 1'b0;
    win_idx = '0;
    if (win_diff[DIFF_WIDTH-1]) begin
      win_idx = '0;
    end else if (win_diff >= SAT_DIFF) begin
      win_idx = SAT_IDX;
      win_sat = 1'b1;
    end else begin
      win_idx = win_diff[5:0];
    end
  end

  // Accept only when the result register is free or being drained this cycle.
  // Reset also blocks accepts, so no requester sees rdy while the block is
  // being cleared.
  always_comb begin
    can_acc       = ~cpurst & ~bus.flush & (~bus.res_vld | bus.res_rdy);
    accept        = can_acc & any_vld;
    bus.req0_rdy  = accept & ~grant;
    bus.req1_rdy  = accept & grant;
    bus.shf_data  = win_frac;
    bus.shf_index = win_idx;
  end

  // Result register and round-robin pointer.
  // A load wins over a drain: a held result leaving and a new one arriving
  // on the same edge simply overwrites the register.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      bus.res_vld  <= 1'b0;
      bus.res_id   <= 1'b0;
      bus.res_data <= '0;
      bus.res_sat  <= 1'b0;
      rr_ptr       <= 1'b0;
    end else if (bus.flush) begin
      bus.res_vld <= 1'b0;
    end else if (accept) begin
      bus.res_vld  <= 1'b1;
      bus.res_id   <= grant;
      bus.res_data <= bus.shf_result;
      bus.res_sat  <= win_sat;
      rr_ptr       <= ~grant;
    end else if (bus.res_rdy) begin
      bus.res_vld <= 1'b0;
    end
  end

endmodule
